// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the MIPS-subset datapath: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handshakes with data memory, traps and counts retirements.
module multicycle_ctrl #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [5:0]  Op,
    input  logic [5:0]  Func,
    input  logic        Z,
    input  logic        MemReady,
    output logic        PCwr,
    output logic        IRwr,
    output logic        Regrt,
    output logic        Se,
    output logic        Aluqb,
    output logic [1:0]  Aluc,
    output logic [1:0]  PCsrc,
    output logic        Wreg,
    output logic        Reg2reg,
    output logic        MemReq,
    output logic        Wmem,
    output logic        Retire,
    output logic [31:0] InstCount,
    output logic        Trap,
    output logic [1:0]  Cause
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [7:0] LP_LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      r_state;
    logic [7:0]  r_wait;
    logic [31:0] r_count;
    logic        r_trap;
    logic [1:0]  r_cause;

    state_t      w_next;
    logic [1:0]  w_cause_nxt;
    logic        w_pcwr, w_irwr, w_wreg, w_memreq, w_wmem, w_retire;
    logic [1:0]  w_alu_c;
    logic        w_alu_qb, w_ext_se;

    logic w_rtype, w_rlegal, w_addi, w_andi, w_ori, w_lw, w_sw, w_beq, w_bne, w_j;
    logic w_imm_alu, w_mem, w_branch, w_legal;

    assign w_rtype   = (Op == 6'b000000);
    assign w_rlegal  = (Func == 6'b100000) || (Func == 6'b100010) ||
                       (Func == 6'b100100) || (Func == 6'b100101);
    assign w_addi    = (Op == 6'b001000);
    assign w_andi    = (Op == 6'b001100);
    assign w_ori     = (Op == 6'b001101);
    assign w_lw      = (Op == 6'b100011);
    assign w_sw      = (Op == 6'b101011);
    assign w_beq     = (Op == 6'b000100);
    assign w_bne     = (Op == 6'b000101);
    assign w_j       = (Op == 6'b000010);
    assign w_imm_alu = w_addi || w_andi || w_ori;
    assign w_mem     = w_lw || w_sw;
    assign w_branch  = w_beq || w_bne;
    assign w_legal   = (w_rtype && w_rlegal) || w_imm_alu || w_mem || w_branch || w_j;

    // ALU/extender selects implied by the instruction; MEM reuses the lw/sw address setting
    always_comb begin
        w_alu_c  = 2'b00;
        w_alu_qb = w_imm_alu || w_mem;
        w_ext_se = w_addi || w_mem || w_branch;
        if (w_rtype) begin
            case (Func)
                6'b100010: w_alu_c = 2'b01;
                6'b100100: w_alu_c = 2'b10;
                6'b100101: w_alu_c = 2'b11;
                default:   w_alu_c = 2'b00;
            endcase
        end else if (w_andi) begin
            w_alu_c = 2'b10;
        end else if (w_ori) begin
            w_alu_c = 2'b11;
        end else if (w_branch) begin
            w_alu_c = 2'b01;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cause_nxt = 2'b00;
        w_pcwr      = 1'b0;
        w_irwr      = 1'b0;
        w_wreg      = 1'b0;
        w_memreq    = 1'b0;
        w_wmem      = 1'b0;
        w_retire    = 1'b0;
        PCsrc       = 2'b00;
        Aluc        = 2'b00;
        Aluqb       = 1'b0;
        Se          = 1'b0;
        Regrt       = 1'b0;
        Reg2reg     = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_irwr = 1'b1;
                w_pcwr = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                if (!w_legal) begin
                    w_next      = S_TRAP;
                    w_cause_nxt = 2'b01;
                end else if (w_j) begin
                    w_pcwr   = 1'b1;
                    PCsrc    = 2'b10;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                Aluc  = w_alu_c;
                Aluqb = w_alu_qb;
                Se    = w_ext_se;
                if (w_branch) begin
                    w_pcwr   = w_beq ? Z : !Z;
                    PCsrc    = 2'b01;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_mem) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                Aluqb    = 1'b1;
                Se       = 1'b1;
                w_memreq = 1'b1;
                w_wmem   = w_sw;
                // Ready on the last allowed cycle still wins over the timeout
                if (MemReady) begin
                    w_retire = w_sw;
                    w_next   = w_sw ? S_FETCH : S_WB;
                end else if (r_wait == LP_LAST_WAIT) begin
                    w_next      = S_TRAP;
                    w_cause_nxt = 2'b10;
                end
            end
            S_WB: begin
                Aluc     = w_alu_c;
                Aluqb    = w_alu_qb;
                Se       = w_ext_se;
                Regrt    = !w_rtype;
                Reg2reg  = w_lw;
                w_wreg   = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    assign PCwr      = w_pcwr   && !Rst;
    assign IRwr      = w_irwr   && !Rst;
    assign Wreg      = w_wreg   && !Rst;
    assign MemReq    = w_memreq && !Rst;
    assign Wmem      = w_wmem   && !Rst;
    assign Retire    = w_retire && !Rst;
    assign InstCount = r_count;
    assign Trap      = r_trap;
    assign Cause     = r_cause;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_FETCH;
            r_wait  <= 8'd0;
            r_count <= 32'd0;
            r_trap  <= 1'b0;
            r_cause <= 2'b00;
        end else begin
            r_state <= w_next;
            r_wait  <= (r_state == S_MEM && !MemReady) ? r_wait + 8'd1 : 8'd0;
            if (w_retire) begin
                r_count <= r_count + 32'd1;
            end
            if (r_state != S_TRAP && w_next == S_TRAP) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause_nxt;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each cycle pushes its expected output set to a
// scoreboard and pops/compares it against the DUT half a clock later.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic        pcwr, irwr;
        logic [1:0]  pcsrc, aluc;
        logic        aluqb, se, regrt, wreg, reg2reg, memreq, wmem, retire, trap;
        logic [1:0]  cause;
        logic [31:0] cnt;
    } exp_t;

    localparam logic [5:0] OP_R = 6'h00, F_ADD = 6'h20, F_SUB = 6'h22, F_BAD = 6'h21;
    localparam logic [5:0] OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02, OP_ILL = 6'h3F;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [5:0]  Op = 6'h00;
    logic [5:0]  Func = 6'h00;
    logic        Z = 1'b0;
    logic        MemReady = 1'b0;
    logic        PCwr, IRwr, Regrt, Se, Aluqb, Wreg, Reg2reg, MemReq, Wmem, Retire, Trap;
    logic [1:0]  Aluc, PCsrc, Cause;
    logic [31:0] InstCount;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    multicycle_ctrl #(.MAX_WAIT(16)) dut (
        .Clk(Clk), .Rst(Rst), .Op(Op), .Func(Func), .Z(Z), .MemReady(MemReady),
        .PCwr(PCwr), .IRwr(IRwr), .Regrt(Regrt), .Se(Se), .Aluqb(Aluqb), .Aluc(Aluc),
        .PCsrc(PCsrc), .Wreg(Wreg), .Reg2reg(Reg2reg), .MemReq(MemReq), .Wmem(Wmem),
        .Retire(Retire), .InstCount(InstCount), .Trap(Trap), .Cause(Cause)
    );

    always #5 Clk = ~Clk;

    function automatic exp_t mk(input logic pcwr, irwr, input logic [1:0] pcsrc, aluc,
                                input logic aluqb, se, regrt, wreg, reg2reg, memreq,
                                input logic wmem, retire, trap, input logic [1:0] cause,
                                input logic [31:0] cnt);
        return {pcwr, irwr, pcsrc, aluc, aluqb, se, regrt, wreg, reg2reg, memreq,
                wmem, retire, trap, cause, cnt};
    endfunction

    function automatic exp_t fe(input logic [31:0] c);
        return mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c);
    endfunction

    function automatic exp_t zz(input logic [31:0] c);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c);
    endfunction

    // One clock: drive inputs after the edge, expect e for this state, check at negedge
    task automatic cyc(input string tag, input logic rst, input logic [5:0] op, fn,
                       input logic z, mr, input exp_t e);
        exp_t want, got;
        @(posedge Clk);
        #1;
        Rst = rst; Op = op; Func = fn; Z = z; MemReady = mr;
        sb.push_back(e);
        @(negedge Clk);
        want = sb.pop_front();
        got  = {PCwr, IRwr, PCsrc, Aluc, Aluqb, Se, Regrt, Wreg, Reg2reg, MemReq,
                Wmem, Retire, Trap, Cause, InstCount};
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    initial begin
        // Reset state
        cyc("rst0", 1, OP_R, F_ADD, 0, 0, zz(0));
        cyc("rst1", 1, OP_R, F_ADD, 0, 0, zz(0));

        // add: FETCH, DECODE, EXEC, WB
        cyc("add_fetch", 0, OP_R, F_ADD, 0, 0, fe(0));
        cyc("add_dec",   0, OP_R, F_ADD, 0, 0, zz(0));
        cyc("add_exec",  0, OP_R, F_ADD, 0, 0, zz(0));
        cyc("add_wb",    0, OP_R, F_ADD, 0, 0, mk(0,0,0,0,0,0,0,1,0,0,0,1,0,0,0));

        // sub
        cyc("sub_fetch", 0, OP_R, F_SUB, 0, 0, fe(1));
        cyc("sub_dec",   0, OP_R, F_SUB, 0, 0, zz(1));
        cyc("sub_exec",  0, OP_R, F_SUB, 0, 0, mk(0,0,0,1,0,0,0,0,0,0,0,0,0,0,1));
        cyc("sub_wb",    0, OP_R, F_SUB, 0, 0, mk(0,0,0,1,0,0,0,1,0,0,0,1,0,0,1));

        // ori: zero-extend, immediate B, rt destination
        cyc("ori_fetch", 0, OP_ORI, 6'h00, 0, 0, fe(2));
        cyc("ori_dec",   0, OP_ORI, 6'h00, 0, 0, zz(2));
        cyc("ori_exec",  0, OP_ORI, 6'h00, 0, 0, mk(0,0,0,3,1,0,0,0,0,0,0,0,0,0,2));
        cyc("ori_wb",    0, OP_ORI, 6'h00, 0, 0, mk(0,0,0,3,1,0,1,1,0,0,0,1,0,0,2));

        // lw: MemReady high outside MEM is ignored, then 3 wait cycles
        cyc("lw_fetch", 0, OP_LW, 6'h00, 0, 1, fe(3));
        cyc("lw_dec",   0, OP_LW, 6'h00, 0, 1, zz(3));
        cyc("lw_exec",  0, OP_LW, 6'h00, 0, 1, mk(0,0,0,0,1,1,0,0,0,0,0,0,0,0,3));
        for (int i = 0; i < 3; i++)
            cyc("lw_memwait", 0, OP_LW, 6'h00, 0, 0, mk(0,0,0,0,1,1,0,0,0,1,0,0,0,0,3));
        cyc("lw_memdone", 0, OP_LW, 6'h00, 0, 1, mk(0,0,0,0,1,1,0,0,0,1,0,0,0,0,3));
        cyc("lw_wb",      0, OP_LW, 6'h00, 0, 0, mk(0,0,0,0,1,1,1,1,1,0,0,1,0,0,3));

        // beq Z=1 taken, bne Z=1 not taken, bne Z=0 taken
        cyc("beq_fetch", 0, OP_BEQ, 6'h00, 1, 0, fe(4));
        cyc("beq_dec",   0, OP_BEQ, 6'h00, 1, 0, zz(4));
        cyc("beq_exec",  0, OP_BEQ, 6'h00, 1, 0, mk(1,0,1,1,0,1,0,0,0,0,0,1,0,0,4));
        cyc("bne_fetch", 0, OP_BNE, 6'h00, 1, 0, fe(5));
        cyc("bne_dec",   0, OP_BNE, 6'h00, 1, 0, zz(5));
        cyc("bne_exec",  0, OP_BNE, 6'h00, 1, 0, mk(0,0,1,1,0,1,0,0,0,0,0,1,0,0,5));
        cyc("bnez_fetch", 0, OP_BNE, 6'h00, 0, 0, fe(6));
        cyc("bnez_dec",   0, OP_BNE, 6'h00, 0, 0, zz(6));
        cyc("bnez_exec",  0, OP_BNE, 6'h00, 0, 0, mk(1,0,1,1,0,1,0,0,0,0,0,1,0,0,6));

        // j retires in DECODE
        cyc("j_fetch", 0, OP_J, 6'h00, 0, 0, fe(7));
        cyc("j_dec",   0, OP_J, 6'h00, 0, 0, mk(1,0,2,0,0,0,0,0,0,0,0,1,0,0,7));

        // sw: ready arrives on the last cycle before timeout (w = MAX_WAIT-1)
        cyc("sw_fetch", 0, OP_SW, 6'h00, 0, 0, fe(8));
        cyc("sw_dec",   0, OP_SW, 6'h00, 0, 0, zz(8));
        cyc("sw_exec",  0, OP_SW, 6'h00, 0, 0, mk(0,0,0,0,1,1,0,0,0,0,0,0,0,0,8));
        for (int i = 0; i < 15; i++)
            cyc("sw_memwait", 0, OP_SW, 6'h00, 0, 0, mk(0,0,0,0,1,1,0,0,0,1,1,0,0,0,8));
        cyc("sw_lastready", 0, OP_SW, 6'h00, 0, 1, mk(0,0,0,0,1,1,0,0,0,1,1,1,0,0,8));

        // Reset during lw MEM wait aborts with no retire
        cyc("abort_fetch", 0, OP_LW, 6'h00, 0, 0, fe(9));
        cyc("abort_dec",   0, OP_LW, 6'h00, 0, 0, zz(9));
        cyc("abort_exec",  0, OP_LW, 6'h00, 0, 0, mk(0,0,0,0,1,1,0,0,0,0,0,0,0,0,9));
        cyc("abort_mem0",  0, OP_LW, 6'h00, 0, 0, mk(0,0,0,0,1,1,0,0,0,1,0,0,0,0,9));
        cyc("abort_mem1",  0, OP_LW, 6'h00, 0, 0, mk(0,0,0,0,1,1,0,0,0,1,0,0,0,0,9));
        cyc("abort_rst",   1, OP_LW, 6'h00, 0, 1, mk(0,0,0,0,1,1,0,0,0,0,0,0,0,0,9));
        cyc("abort_rst2",  1, OP_LW, 6'h00, 0, 1, zz(0));
        cyc("post_fetch",  0, OP_J, 6'h00, 0, 0, fe(0));
        cyc("post_j_dec",  0, OP_J, 6'h00, 0, 0, mk(1,0,2,0,0,0,0,0,0,0,0,1,0,0,0));

        // sw timeout: 16 MEM cycles, then sticky trap with all enables low
        cyc("to_fetch", 0, OP_SW, 6'h00, 0, 0, fe(1));
        cyc("to_dec",   0, OP_SW, 6'h00, 0, 0, zz(1));
        cyc("to_exec",  0, OP_SW, 6'h00, 0, 0, mk(0,0,0,0,1,1,0,0,0,0,0,0,0,0,1));
        for (int i = 0; i < 16; i++)
            cyc("to_memwait", 0, OP_SW, 6'h00, 0, 0, mk(0,0,0,0,1,1,0,0,0,1,1,0,0,0,1));
        for (int i = 0; i < 3; i++)
            cyc("to_trap", 0, OP_SW, 6'h00, 0, 1, mk(0,0,0,0,0,0,0,0,0,0,0,0,1,2,1));
        cyc("to_rst",  1, OP_SW, 6'h00, 0, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,1,2,1));
        cyc("to_rst2", 1, OP_SW, 6'h00, 0, 0, zz(0));

        // Illegal opcode
        cyc("ill_fetch", 0, OP_ILL, 6'h00, 0, 0, fe(0));
        cyc("ill_dec",   0, OP_ILL, 6'h00, 0, 0, zz(0));
        cyc("ill_trap0", 0, OP_ILL, 6'h00, 0, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,1,1,0));
        cyc("ill_trap1", 0, OP_J,   6'h00, 0, 1, mk(0,0,0,0,0,0,0,0,0,0,0,0,1,1,0));
        cyc("ill_rst",   1, OP_R,   F_BAD, 0, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,1,1,0));
        cyc("ill_rst2",  1, OP_R,   F_BAD, 0, 0, zz(0));

        // Illegal funct with R-type opcode
        cyc("bad_fetch", 0, OP_R, F_BAD, 0, 0, fe(0));
        cyc("bad_dec",   0, OP_R, F_BAD, 0, 0, zz(0));
        cyc("bad_trap",  0, OP_R, F_BAD, 0, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,1,1,0));
        cyc("bad_rst",   1, OP_R, F_ADD, 0, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,1,1,0));
        cyc("bad_rst2",  1, OP_R, F_ADD, 0, 0, zz(0));
        cyc("final_fetch", 0, OP_R, F_ADD, 0, 0, fe(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
